cdc_rd_arbiter: RTL and testbench
=================================

Name: cdc_rd_arbiter

Overview:
- Read-side scheduler that shares one downstream flit port among CHANNELS CDC FIFOs. All FIFOs sit in the same read clock domain.
- Arbitration is round-robin and packet-aware: each pop drives the FIFO's rd_inc, and the arbiter holds a grant until the packet's last flit.
- One registered output stage with valid/ready handshake. Sits between the CDC FIFO read ports and the local NoC/bus interface.

Parameters:
- CHANNELS, 4, number of CDC FIFO read ports served (2..16).
- DW, 32, payload width per flit, excluding the last bit.
- CW, $clog2(CHANNELS) (min 1), derived width of the channel index; not overridable.

Ports:
- rd_clk  in  1  read-domain clock.
- rd_rst  in  1  reset; one clock; reset is synchronous and active-low.
- rd_empty  in  CHANNELS  per-FIFO empty flag, registered in the FIFO.
- rd_data  in  CHANNELS*(DW+1)  per-FIFO head flit. Slice i is [i*(DW+1) +: DW+1]; bit DW of each slice = last.
- rd_inc  out  CHANNELS  per-FIFO pop strobe, combinational.
- out_valid  out  1  output flit valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DW  output payload.
- out_last  out  1  output last-flit marker.
- out_chan  out  CW  source channel of the current output flit.

Behaviour:
- Reset (rd_rst==0 at a rd_clk edge):
  - state=IDLE, rr_ptr=0, out_valid=0, out_data=0, out_last=0, out_chan=0.
  - rd_inc=0 throughout the reset cycle.
- can_accept = !out_valid | out_ready. The output register loads only when can_accept=1.
- FSM states IDLE and LOCKED; the grant register gnt (CW bits) is held while LOCKED.
- IDLE:
  - Pick the first i with rd_empty[i]==0, scanning from rr_ptr upward mod CHANNELS.
  - If one exists and can_accept=1: rd_inc[i]=1 and the flit loads into the output register.
  - If that flit has last=1: stay IDLE and set rr_ptr=(i+1) mod CHANNELS.
  - If last=0: go to LOCKED with gnt=i.
  - If no channel is non-empty, or can_accept=0: no pop, rr_ptr unchanged.
- LOCKED:
  - Serve only gnt. If rd_empty[gnt]==0 and can_accept=1, pop and load.
  - On a last=1 pop: go to IDLE and set rr_ptr=(gnt+1) mod CHANNELS.
  - If gnt is empty: wait indefinitely. No other channel is served; no timeout.
- rd_inc:
  - At most one bit set per cycle.
  - Never asserted for an empty channel.
  - Never asserted when can_accept=0.
- Latency: a head flit popped in cycle t appears on out_* in cycle t+1. Back-to-back flits from one channel give full throughput (1 flit/cycle while out_ready=1).
- Output hold: when out_valid=1 and out_ready=0, out_data, out_last and out_chan are held stable.
- Simultaneous out_ready=1 and new pop: the output register is replaced in the same edge, with no bubble.
- Wrap-around: rr_ptr increments modulo CHANNELS, including non-power-of-two CHANNELS.
- Mid-operation reset:
  - A partially forwarded packet is abandoned and state returns to IDLE.
  - FIFO contents are not flushed; the system resets the FIFOs together with the arbiter.

Optional Feature:
- Macro CDC_RD_ARB_PKT_LOCK_EN.
- Defined: packet locking as described above.
- Undefined:
  - The LOCKED state is not built.
  - Every pop acts as last for arbitration: rr_ptr advances after every flit, giving flit-level round-robin.
  - out_last is still passed through unchanged.

Decomposition:
- Shared package cdc_pkg holds:
  - FSM state enum (ARB_IDLE=1'b0, ARB_LOCKED=1'b1).
  - Function for flit slice extraction.
  - Localparam rule for CW.
- Sub-module cdc_rr_select:
  - Combinational rotate-priority finder.
  - Inputs: req vector, rr_ptr. Outputs: found, index.
  - Reusable by the write-side scheduler.

Test Plan:
- Reset: hold rd_rst=0 for 3 cycles with all FIFOs non-empty -> rd_inc=0, out_valid=0, out_chan=0; first pop in the cycle after release is from ch0.
- Round-robin: CHANNELS=4; ch0, ch2, ch3 each hold one last=1 flit; out_ready=1 -> out_chan sequence 0,2,3 on consecutive cycles, then rr_ptr=0.
- Lock: ch1 holds 3-flit packet A (last on 3rd), ch0 holds 1-flit B; ch1 empties for 2 cycles after flit 1 -> out sequence A1, A2, A3, then B. Ch0 is never popped while locked. Without the macro: A1, B, A2, A3.
- Backpressure: out_ready=0 for 5 cycles with out_valid=1 -> rd_inc=0 and out_data stable for all 5 cycles; on out_ready=1, the next flit appears the following cycle.
- Throughput: ch3 holds 8 flits, out_ready=1 -> out_valid continuous for 8 cycles, and rd_inc[3] high for 8 consecutive cycles.
- Mid-packet reset: assert rd_rst=0 after 2 of 4 flits of a ch2 packet -> state IDLE, out_valid=0; with ch0 non-empty, the next pop is from ch0.

Source files
------------

// File: rtl/cdc_pkg.sv
// Shared definitions for the CDC FIFO read/write schedulers.
//
// Contents:
//   arbState_e   - arbiter FSM state encoding (idle / locked to a packet).
//   chanIdxWidth - width of a channel index for a given channel count, never below 1.
//   flitBase     - bit offset of a channel's flit inside a flattened
//                  {last, payload} per-channel bus.
package cdc_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arbState_e;

  // A single channel still needs one index bit so that ports never collapse to zero width.
  function automatic int chanIdxWidth(input int channels);
    return (channels > 2) ? $clog2(channels) : 1;
  endfunction

  // Each channel slot carries DW payload bits plus the last marker on top.
  function automatic int flitBase(input int chan, input int dw);
    return chan * (dw + 1);
  endfunction

endpackage

// File: rtl/cdc_rr_select.sv
// Rotating-priority finder.
//
// Returns the first asserted request at or after rrPtr_i, wrapping modulo N.
// The logic is purely combinational, so it can be shared with the write-side scheduler.
//
// Ports:
//   req_i    [N-1:0]  request vector (1 = channel wants service)
//   rrPtr_i  [W-1:0]  channel with highest priority this cycle (< N)
//   found_o           at least one request is asserted
//   index_o  [W-1:0]  winning channel, valid when found_o=1
module cdc_rr_select #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] rrPtr_i,
  output logic         found_o,
  output logic [W-1:0] index_o
);

  logic [2*N-1:0] reqTwice;
  logic [N-1:0]   reqRotated;

  // Rotate the request vector so that bit 0 is the current priority holder.
  // Requests that wrap past the top come back in through the duplicated upper copy.
  assign reqTwice   = {req_i, req_i} >> rrPtr_i;
  assign reqRotated = reqTwice[N-1:0];

  // Take the lowest set bit of the rotated vector.
  // Then map its position back to an absolute channel number.
  always_comb begin
    found_o = 1'b0;
    index_o = '0;
    for (int j = 0; j < N; j++) begin
      if (!found_o && reqRotated[j]) begin
        found_o = 1'b1;
        index_o = W'((int'(rrPtr_i) + j >= N) ? int'(rrPtr_i) + j - N
                                                : int'(rrPtr_i) + j);
      end
    end
  end

endmodule

// File: rtl/cdc_rd_arbiter.sv
// Read-side scheduler.
//
// The scheduler shares one registered flit output among CHANNELS CDC FIFOs.
// All FIFOs are in the read clock domain. Arbitration is round-robin.
// With CDC_RD_ARB_PKT_LOCK_EN defined, the grant is held from a packet's
// first flit to its last flit. Without it, the pointer advances after every
// flit, and out_last is only passed through.
//
// Ports:
//   rd_clk     read-domain clock
//   rd_rst     synchronous active-low reset
//   rd_empty   per-FIFO empty flag
//   rd_data    per-FIFO head flit, slice i = [i*(DW+1) +: DW+1], top bit = last
//   rd_inc     per-FIFO pop strobe (combinational, at most one hot)
//   out_valid  output flit valid
//   out_ready  downstream accepts the output flit
//   out_data   output payload
//   out_last   output last-flit marker
//   out_chan   source channel of the output flit
//
// Build option: CDC_RD_ARB_PKT_LOCK_EN enables packet locking.
module cdc_rd_arbiter
  import cdc_pkg::*;
#(
  parameter  int CHANNELS = 4,
  parameter  int DW       = 32,
  localparam int CW       = chanIdxWidth(CHANNELS)
) (
  input  logic                         rd_clk,
  input  logic                         rd_rst,
  input  logic [CHANNELS-1:0]          rd_empty,
  input  logic [CHANNELS*(DW+1)-1:0]   rd_data,
  output logic [CHANNELS-1:0]          rd_inc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DW-1:0]                out_data,
  output logic                         out_last,
  output logic [CW-1:0]                out_chan
);

  localparam int FW = DW + 1;

  logic          canAccept;
  logic          selFound;
  logic [CW-1:0] selIdx;
  logic          popEn;
  logic [CW-1:0] popChan;
  logic [FW-1:0] popFlit;
  logic [CW-1:0] rrNext;
  logic [CW-1:0] rrPtr_q, rrPtr_d;
  logic          outValid_q;
  logic [DW-1:0] outData_q;
  logic          outLast_q;
  logic [CW-1:0] outChan_q;

`ifdef CDC_RD_ARB_PKT_LOCK_EN
  arbState_e     state_q, state_d;
  logic [CW-1:0] gnt_q, gnt_d;
`endif

  // The output slot is free when it is empty or being drained this edge.
  // This lets a new flit replace the old one without a bubble.
  assign canAccept = !outValid_q || out_ready;

  cdc_rr_select #(
    .N(CHANNELS),
    .W(CW)
  ) uRrSelect (
    .req_i  (~rd_empty),
    .rrPtr_i(rrPtr_q),
    .found_o(selFound),
    .index_o(selIdx)
  );

  // Choose the channel served this cycle.
  // While locked, only the granted channel may be popped.
  // The arbiter then waits for that channel even if others have data.
  always_comb begin
    popChan = selIdx;
    popEn   = selFound && canAccept;
`ifdef CDC_RD_ARB_PKT_LOCK_EN
    if (state_q == ARB_LOCKED) begin
      popChan = gnt_q;
      popEn   = !rd_empty[gnt_q] && canAccept;
    end
`endif
  end

  assign popFlit = FW'(rd_data >> flitBase(int'(popChan), DW));
  assign rrNext  = (int'(popChan) == CHANNELS - 1) ? '0 : popChan + 1'b1;

  // Pointer, grant and state registers.
  // Reset abandons any packet in flight.
  // The FIFOs are expected to be reset alongside the arbiter.
  always_ff @(posedge rd_clk) begin
    if (!rd_rst) begin
      rrPtr_q <= '0;
    end else begin
      rrPtr_q <= rrPtr_d;
    end
  end

`ifdef CDC_RD_ARB_PKT_LOCK_EN
  always_ff @(posedge rd_clk) begin
    if (!rd_rst) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
    end
  end
`endif

  // Next-state logic.
  // With locking, only a last flit releases the channel and moves the pointer past it.
  // Without locking, every pop moves the pointer.
  always_comb begin
    rrPtr_d = rrPtr_q;
`ifdef CDC_RD_ARB_PKT_LOCK_EN
    state_d = state_q;
    gnt_d   = gnt_q;
    if (popEn) begin
      if (popFlit[DW]) begin
        state_d = ARB_IDLE;
        rrPtr_d = rrNext;
      end else begin
        state_d = ARB_LOCKED;
        gnt_d   = popChan;
      end
    end
`else
    if (popEn) begin
      rrPtr_d = rrNext;
    end
`endif
  end

  // Pop strobe.
  // It is gated by reset so that no FIFO loses a flit while the arbiter is being cleared.
  always_comb begin
    rd_inc = '0;
    if (popEn && rd_rst) begin
      rd_inc[popChan] = 1'b1;
    end
  end

  // Output register.
  // It loads only when the slot is free. While stalled, the flit is held untouched.
  always_ff @(posedge rd_clk) begin
    if (!rd_rst) begin
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outLast_q  <= 1'b0;
      outChan_q  <= '0;
    end else if (canAccept) begin
      outValid_q <= popEn;
      if (popEn) begin
        outData_q <= popFlit[DW-1:0];
        outLast_q <= popFlit[DW];
        outChan_q <= popChan;
      end
    end
  end

  assign out_valid = outValid_q;
  assign out_data  = outData_q;
  assign out_last  = outLast_q;
  assign out_chan  = outChan_q;

endmodule

// File: tb/tb_cdc_rd_arbiter.sv
// Self-checking bench for cdc_rd_arbiter.
//
// FIFOs are modelled as queues.
// Expected output flits are queued in the order the arbiter should deliver them.
// Each accepted output flit is compared against that queue.
// Pop-strobe rules are checked on every cycle.
module tb_cdc_rd_arbiter;

  localparam int CH = 4;
  localparam int DW = 32;
  localparam int FW = DW + 1;

  typedef struct packed {
    logic [1:0]    chan;
    logic [DW-1:0] data;
    logic          last;
  } flit_t;

  logic           clk = 1'b0;
  logic           rstN;
  logic [CH-1:0]  rdEmpty;
  logic [CH*FW-1:0] rdData;
  logic [CH-1:0]  rdInc;
  logic           outValid;
  logic           outReady;
  logic [DW-1:0]  outData;
  logic           outLast;
  logic [1:0]     outChan;

  logic [DW:0] fifoQ [CH][$];
  flit_t       sb [$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  cdc_rd_arbiter #(
    .CHANNELS(CH),
    .DW      (DW)
  ) dut (
    .rd_clk   (clk),
    .rd_rst   (rstN),
    .rd_empty (rdEmpty),
    .rd_data  (rdData),
    .rd_inc   (rdInc),
    .out_valid(outValid),
    .out_ready(outReady),
    .out_data (outData),
    .out_last (outLast),
    .out_chan (outChan)
  );

  // One comparison: count it, and report it if it does not hold.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present each FIFO's empty flag and head flit on the DUT inputs.
  task automatic updatePins();
    for (int i = 0; i < CH; i++) begin
      rdEmpty[i] = (fifoQ[i].size() == 0);
      if (fifoQ[i].size() == 0) rdData[i*FW +: FW] = '0;
      else                      rdData[i*FW +: FW] = fifoQ[i][0];
    end
  endtask

  // Write one flit into a FIFO model.
  task automatic applyStimulus(input int ch, input logic [DW-1:0] data, input logic last);
    fifoQ[ch].push_back({last, data});
    updatePins();
  endtask

  // Queue the next flit the output is expected to deliver.
  task automatic expectFlit(input int ch, input logic [DW-1:0] data, input logic last);
    flit_t f;
    f.chan = 2'(ch);
    f.data = data;
    f.last = last;
    sb.push_back(f);
  endtask

  // Advance one clock cycle, starting and ending on a falling edge.
  // The strobe rules and any handshake about to complete are checked first.
  // After the rising edge, the FIFOs pop what the DUT strobed.
  task automatic tick();
    logic [CH-1:0] popMask;
    flit_t         expFlit;
    #1;
    checkOutput("inc_onehot", 64'($countones(rdInc) <= 1), 64'd1);
    checkOutput("inc_on_empty", 64'(rdInc & rdEmpty), 64'd0);
    if (outValid === 1'b1 && outReady === 1'b0)
      checkOutput("inc_while_stalled", 64'(rdInc), 64'd0);
    if (outValid === 1'b1 && outReady === 1'b1) begin
      checkOutput("unexpected_flit", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        expFlit = sb.pop_front();
        checkOutput("out_chan", 64'(outChan), 64'(expFlit.chan));
        checkOutput("out_data", 64'(outData), 64'(expFlit.data));
        checkOutput("out_last", 64'(outLast), 64'(expFlit.last));
      end
    end
    popMask = rdInc;
    @(posedge clk);
    #1;
    for (int i = 0; i < CH; i++)
      if (popMask[i] && fifoQ[i].size() != 0) void'(fifoQ[i].pop_front());
    updatePins();
    @(negedge clk);
  endtask

  task automatic runCycles(input int n);
    repeat (n) tick();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [CH-1:0] rrIncSeq [3];
    rrIncSeq[0] = 4'b0001;
    rrIncSeq[1] = 4'b0100;
    rrIncSeq[2] = 4'b1000;

    rstN     = 1'b0;
    outReady = 1'b1;
    updatePins();
    @(negedge clk);

    $display("[TB] reset with all FIFOs non-empty");
    for (int c = 0; c < CH; c++) begin
      applyStimulus(c, 32'hA0 + c, 1'b1);
      expectFlit(c, 32'hA0 + c, 1'b1);
    end
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput("rst_inc", 64'(rdInc), 64'd0);
      checkOutput("rst_valid", 64'(outValid), 64'd0);
      checkOutput("rst_chan", 64'(outChan), 64'd0);
      tick();
    end
    rstN = 1'b1;
    #1;
    checkOutput("first_pop_ch0", 64'(rdInc), 64'h1);
    tick();
    runCycles(5);

    $display("[TB] round-robin over ch0, ch2, ch3");
    applyStimulus(0, 32'hB0, 1'b1);
    applyStimulus(2, 32'hB2, 1'b1);
    applyStimulus(3, 32'hB3, 1'b1);
    expectFlit(0, 32'hB0, 1'b1);
    expectFlit(2, 32'hB2, 1'b1);
    expectFlit(3, 32'hB3, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput("rr_seq_inc", 64'(rdInc), 64'(rrIncSeq[k]));
      tick();
    end
    runCycles(2);
    applyStimulus(3, 32'hB4, 1'b1);
    applyStimulus(0, 32'hB5, 1'b1);
    expectFlit(0, 32'hB5, 1'b1);
    expectFlit(3, 32'hB4, 1'b1);
    #1;
    checkOutput("rr_wrap_to_ch0", 64'(rdInc), 64'h1);
    runCycles(3);
    applyStimulus(0, 32'hB6, 1'b1);
    expectFlit(0, 32'hB6, 1'b1);
    runCycles(2);

    $display("[TB] packet lock on ch1 with ch0 waiting");
    applyStimulus(1, 32'hA1, 1'b0);
    applyStimulus(0, 32'hBB, 1'b1);
`ifdef CDC_RD_ARB_PKT_LOCK_EN
    expectFlit(1, 32'hA1, 1'b0);
    expectFlit(1, 32'hA2, 1'b0);
    expectFlit(1, 32'hA3, 1'b1);
    expectFlit(0, 32'hBB, 1'b1);
`else
    expectFlit(1, 32'hA1, 1'b0);
    expectFlit(0, 32'hBB, 1'b1);
    expectFlit(1, 32'hA2, 1'b0);
    expectFlit(1, 32'hA3, 1'b1);
`endif
    #1;
    checkOutput("lock_first_a1", 64'(rdInc), 64'h2);
    tick();
    #1;
`ifdef CDC_RD_ARB_PKT_LOCK_EN
    checkOutput("lock_hold_1", 64'(rdInc), 64'h0);
`else
    checkOutput("lock_hold_1", 64'(rdInc), 64'h1);
`endif
    tick();
    #1;
    checkOutput("lock_hold_2", 64'(rdInc), 64'h0);
    tick();
    applyStimulus(1, 32'hA2, 1'b0);
    applyStimulus(1, 32'hA3, 1'b1);
    #1;
    checkOutput("lock_resume_a2", 64'(rdInc), 64'h2);
    tick();
    runCycles(4);

    $display("[TB] backpressure for 5 cycles");
    applyStimulus(2, 32'hD0, 1'b1);
    applyStimulus(2, 32'hD1, 1'b1);
    expectFlit(2, 32'hD0, 1'b1);
    expectFlit(2, 32'hD1, 1'b1);
    tick();
    outReady = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checkOutput("bp_valid", 64'(outValid), 64'd1);
      checkOutput("bp_data_hold", 64'(outData), 64'hD0);
      checkOutput("bp_no_inc", 64'(rdInc), 64'd0);
      tick();
    end
    outReady = 1'b1;
    #1;
    checkOutput("bp_resume_pop", 64'(rdInc), 64'h4);
    tick();
    #1;
    checkOutput("bp_next_valid", 64'(outValid), 64'd1);
    checkOutput("bp_next_data", 64'(outData), 64'hD1);
    runCycles(2);

    $display("[TB] throughput: 8 flits from ch3");
    for (int k = 0; k < 8; k++) begin
      applyStimulus(3, 32'hE0 + k, (k == 7));
      expectFlit(3, 32'hE0 + k, (k == 7));
    end
    for (int k = 0; k < 9; k++) begin
      #1;
      if (k < 8) checkOutput("tp_inc_ch3", 64'(rdInc), 64'h8);
      else       checkOutput("tp_inc_done", 64'(rdInc), 64'h0);
      if (k > 0) checkOutput("tp_valid", 64'(outValid), 64'd1);
      tick();
    end
    runCycles(1);

    $display("[TB] reset in the middle of a ch2 packet");
    for (int k = 0; k < 4; k++)
      applyStimulus(2, 32'hF0 + k, (k == 3));
    expectFlit(2, 32'hF0, 1'b0);
    tick();
    tick();
    rstN     = 1'b0;
    outReady = 1'b0;
    applyStimulus(0, 32'hC0, 1'b1);
    applyStimulus(3, 32'hC3, 1'b1);
    #1;
    checkOutput("mid_rst_inc", 64'(rdInc), 64'd0);
    tick();
    rstN     = 1'b1;
    outReady = 1'b1;
    expectFlit(0, 32'hC0, 1'b1);
`ifdef CDC_RD_ARB_PKT_LOCK_EN
    expectFlit(2, 32'hF2, 1'b0);
    expectFlit(2, 32'hF3, 1'b1);
    expectFlit(3, 32'hC3, 1'b1);
`else
    expectFlit(2, 32'hF2, 1'b0);
    expectFlit(3, 32'hC3, 1'b1);
    expectFlit(2, 32'hF3, 1'b1);
`endif
    #1;
    checkOutput("mid_rst_valid", 64'(outValid), 64'd0);
    checkOutput("mid_rst_chan", 64'(outChan), 64'd0);
    checkOutput("mid_rst_pop_ch0", 64'(rdInc), 64'h1);
    tick();
    runCycles(6);

    checkOutput("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
